// File: rtl/nasti_ram_write_slave.sv
// NASTI write-channel slave: takes one AW burst at a time, turns every W beat into a
// registered single-port RAM write, and answers each burst with a single B response.
module nasti_ram_write_slave #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MEM_DEPTH  = 64,
  localparam int unsigned BYTES     = DATA_WIDTH / 8,
  localparam int unsigned MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // AW channel
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]            aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic [USER_WIDTH-1:0] aw_user,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  // W channel
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [BYTES-1:0]      w_strb,
  input  logic                  w_last,
  input  logic [USER_WIDTH-1:0] w_user,
  input  logic                  w_valid,
  output logic                  w_ready,
  // B channel
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic [USER_WIDTH-1:0] b_user,
  output logic                  b_valid,
  input  logic                  b_ready,
  // RAM write port
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BYTES-1:0]      mem_wstrb
);

  localparam int unsigned BYTES_LOG = $clog2(BYTES);
  localparam logic [2:0] MAX_SIZE = 3'(BYTES_LOG);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e                state_q, state_d;
  logic                  init_q, init_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]      mem_wstrb_q, mem_wstrb_d;

  logic                  aw_fire, w_fire, b_fire;
  logic                  bad_cfg, last_beat, in_range;
  logic [ADDR_WIDTH-1:0] word, incr, addr_next;
  logic                  unused_w;

  assign unused_w = ^w_user;

  assign aw_ready = (state_q == StIdle) && init_q;
  assign w_ready  = (state_q == StData);
  assign b_valid  = (state_q == StResp);
  assign aw_fire  = aw_valid && aw_ready;
  assign w_fire   = w_valid && w_ready;
  assign b_fire   = b_valid && b_ready;

  assign b_id      = id_q;
  assign b_user    = user_q;
  assign b_resp    = {err_q, 1'b0};
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  // WRAP and the reserved encoding are refused, as is any beat wider than the bus.
  assign bad_cfg   = aw_burst[1] || (aw_size > MAX_SIZE);
  assign last_beat = (beat_q == len_q);
  assign word      = addr_q >> BYTES_LOG;
  assign in_range  = {1'b0, word} < DEPTH_W;

  // First INCR beat may be unaligned; every following beat lands on a size boundary.
  assign incr      = ADDR_WIDTH'(1) << size_q;
  assign addr_next = (burst_q == BurstIncr) ? ((addr_q & ~(incr - ADDR_WIDTH'(1))) + incr)
                                            : addr_q;

  always_comb begin
    state_d     = state_q;
    init_d      = 1'b1;
    id_d        = id_q;
    user_d      = user_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    cfg_err_d   = cfg_err_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (aw_fire) begin
          id_d      = aw_id;
          user_d    = aw_user;
          addr_d    = aw_addr;
          len_d     = aw_len;
          size_d    = aw_size;
          burst_d   = aw_burst;
          beat_d    = 8'd0;
          cfg_err_d = bad_cfg;
          err_d     = bad_cfg;
          state_d   = StData;
        end
      end
      StData: begin
        if (w_fire) begin
          // A w_last mismatch only flags the response; the beat still writes.
          if (!cfg_err_q && in_range) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word[MEM_AW-1:0];
            mem_wdata_d = w_data;
            mem_wstrb_d = w_strb;
          end
          err_d  = err_q | ~in_range | (w_last != last_beat);
          addr_d = (burst_q == BurstFixed) ? addr_q : addr_next;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = StResp;
        end
      end
      StResp: begin
        if (b_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      init_q      <= 1'b0;
      id_q        <= '0;
      user_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      cfg_err_q   <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      id_q        <= id_d;
      user_q      <= user_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      cfg_err_q   <= cfg_err_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_nasti_ram_write_slave.sv
// Directed bench for nasti_ram_write_slave: drives on the falling edge, samples on the
// falling edge, and logs every RAM write seen so bursts can be checked afterwards.
module tb_nasti_ram_write_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] aw_id = '0;
  logic [7:0] aw_addr = '0;
  logic [7:0] aw_len = '0;
  logic [2:0] aw_size = '0;
  logic [1:0] aw_burst = '0;
  logic [0:0] aw_user = '0;
  logic       aw_valid = 1'b0;
  logic       aw_ready;
  logic [7:0] w_data = '0;
  logic [0:0] w_strb = '0;
  logic       w_last = 1'b0;
  logic [0:0] w_user = '0;
  logic       w_valid = 1'b0;
  logic       w_ready;
  logic [0:0] b_id;
  logic [1:0] b_resp;
  logic [0:0] b_user;
  logic       b_valid;
  logic       b_ready = 1'b0;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [0:0] mem_wstrb;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  logic [5:0] wa_log[$];
  logic [7:0] wd_log[$];

  always #5 clk = ~clk;

  nasti_ram_write_slave dut (
    .clk      (clk),
    .rst      (rst),
    .aw_id    (aw_id),
    .aw_addr  (aw_addr),
    .aw_len   (aw_len),
    .aw_size  (aw_size),
    .aw_burst (aw_burst),
    .aw_user  (aw_user),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .w_last   (w_last),
    .w_user   (w_user),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .b_id     (b_id),
    .b_resp   (b_resp),
    .b_user   (b_user),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      wr_count++;
      wa_log.push_back(mem_addr);
      wd_log.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_aw(input logic id, input logic [7:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd0; aw_burst = burst;
    aw_user = id; aw_valid = 1'b1;
    while (!aw_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("aw_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  // One beat with an idle cycle after it, so the one-cycle mem_we pulse is visible.
  task automatic send_w(input logic [7:0] data, input logic last, input logic exp_we,
                        input logic [5:0] exp_addr);
    int n = 0;
    w_data = data; w_strb = 1'b1; w_last = last; w_user = 1'b0; w_valid = 1'b1;
    while (!w_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("w_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    w_valid = 1'b0;
    check("mem_we_after_beat", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(data));
      check("mem_wstrb", 32'(mem_wstrb), 32'd1);
    end
    @(negedge clk);
    check("mem_we_pulse", 32'(mem_we), 32'd0);
  endtask

  task automatic wait_b(input logic exp_id, input logic [1:0] exp_resp);
    int n = 0;
    while (!b_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_valid", 32'(b_valid), 32'd1);
    check("b_id", 32'(b_id), 32'(exp_id));
    check("b_user", 32'(b_user), 32'(exp_id));
    check("b_resp", 32'(b_resp), 32'(exp_resp));
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("b_valid_drop", 32'(b_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset values and aw_ready start-up latency
    @(negedge clk);
    check("rst_aw_ready", 32'(aw_ready), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_b_resp", 32'(b_resp), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    rst = 1'b0;
    #1;
    check("aw_ready_at_release", 32'(aw_ready), 32'd0);
    @(negedge clk);
    check("aw_ready_one_cycle_later", 32'(aw_ready), 32'd1);

    // INCR len=3 from 0x10
    wr_count = 0;
    do_aw(1'b1, 8'h10, 8'd3, 2'b01);
    send_w(8'hA0, 1'b0, 1'b1, 6'h10);
    send_w(8'hA1, 1'b0, 1'b1, 6'h11);
    send_w(8'hA2, 1'b0, 1'b1, 6'h12);
    send_w(8'hA3, 1'b1, 1'b1, 6'h13);
    wait_b(1'b1, 2'b00);
    check("incr_writes", 32'(wr_count), 32'd4);

    // FIXED len=2 at 0x05: every beat hits the same word, last data wins
    wr_count = 0;
    base = wa_log.size();
    do_aw(1'b0, 8'h05, 8'd2, 2'b00);
    send_w(8'h11, 1'b0, 1'b1, 6'h05);
    send_w(8'h22, 1'b0, 1'b1, 6'h05);
    send_w(8'h33, 1'b1, 1'b1, 6'h05);
    wait_b(1'b0, 2'b00);
    check("fixed_writes", 32'(wr_count), 32'd3);
    check("fixed_last_addr", 32'(wa_log[base+2]), 32'h05);
    check("fixed_last_data", 32'(wd_log[base+2]), 32'h33);

    // Early w_last on beat 1: all beats still written, SLVERR
    wr_count = 0;
    do_aw(1'b1, 8'h20, 8'd3, 2'b01);
    send_w(8'hC0, 1'b0, 1'b1, 6'h20);
    send_w(8'hC1, 1'b1, 1'b1, 6'h21);
    send_w(8'hC2, 1'b0, 1'b1, 6'h22);
    send_w(8'hC3, 1'b1, 1'b1, 6'h23);
    wait_b(1'b1, 2'b10);
    check("early_last_writes", 32'(wr_count), 32'd4);

    // WRAP burst: beats consumed, nothing written, SLVERR
    wr_count = 0;
    do_aw(1'b0, 8'h00, 8'd1, 2'b10);
    send_w(8'hD0, 1'b0, 1'b0, 6'h00);
    send_w(8'hD1, 1'b1, 1'b0, 6'h00);
    wait_b(1'b0, 2'b10);
    check("wrap_writes", 32'(wr_count), 32'd0);

    // Address 0x50 is past the 64-word RAM
    wr_count = 0;
    do_aw(1'b1, 8'h50, 8'd1, 2'b01);
    send_w(8'hE0, 1'b0, 1'b0, 6'h00);
    send_w(8'hE1, 1'b1, 1'b0, 6'h00);
    wait_b(1'b1, 2'b10);
    check("oob_writes", 32'(wr_count), 32'd0);

    // B back-pressure: payload held, no new AW until the handshake
    do_aw(1'b1, 8'h02, 8'd0, 2'b01);
    send_w(8'h5A, 1'b1, 1'b1, 6'h02);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_b_valid", 32'(b_valid), 32'd1);
      check("stall_b_id", 32'(b_id), 32'd1);
      check("stall_b_resp", 32'(b_resp), 32'd0);
      check("stall_aw_ready", 32'(aw_ready), 32'd0);
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("aw_ready_after_b", 32'(aw_ready), 32'd1);
    check("b_valid_after_b", 32'(b_valid), 32'd0);

    // Reset in the middle of a 4-beat burst
    wr_count = 0;
    do_aw(1'b0, 8'h30, 8'd3, 2'b01);
    send_w(8'hF0, 1'b0, 1'b1, 6'h30);
    w_data = 8'hF1; w_strb = 1'b1; w_last = 1'b0; w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    check("mid_mem_we_before_rst", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_w_ready", 32'(w_ready), 32'd0);
    check("mid_rst_aw_ready", 32'(aw_ready), 32'd0);
    check("mid_rst_b_valid", 32'(b_valid), 32'd0);
    check("mid_rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_b_after_rst", 32'(b_valid), 32'd0);
    end
    check("rst_burst_writes", 32'(wr_count), 32'd2);
    do_aw(1'b1, 8'h01, 8'd0, 2'b01);
    send_w(8'h77, 1'b1, 1'b1, 6'h01);
    wait_b(1'b1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
